path_replayer: RTL and testbench

- Read-side controller for the 2-bit direction store written by the maze-solver datapath.
- On start, repeatedly pops direction codes from the store until it is empty.
- Converts each code into an absolute (x,y) position and presents one move per valid/ready handshake to the downstream move executor or display.
- Flags an error and stops if a move would leave the grid.

---
 rtl/path_pkg.sv | 22 ++
 rtl/dir_step.sv | 28 ++
 rtl/path_replayer.sv | 114 +++++++++++
 tb/tb_path_replayer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/path_pkg.sv
// Shared types and default widths for the path replay read side.
package path_pkg;

   localparam int unsigned COORD_W_DEF = 4;
   localparam int unsigned CNT_W_DEF   = 9;

   typedef enum logic [1:0] {
      UP    = 2'b00,
      RIGHT = 2'b01,
      LEFT  = 2'b10,
      DOWN  = 2'b11
   } dir_t;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      CAP,
      SHOW,
      DONE
   } state_t;

endpackage

// File: rtl/dir_step.sv
// One grid step from (x,y) in direction dir; oob flags a step off the grid edge.
module dir_step
   import path_pkg::*;
#(
   parameter int unsigned COORD_W = COORD_W_DEF
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  dir_t               dir,
   output logic [COORD_W-1:0] nx,
   output logic [COORD_W-1:0] ny,
   output logic               oob
);

   always_comb begin
      nx  = x;
      ny  = y;
      oob = 1'b0;
      unique case (dir)
         UP:    if (y == '0) oob = 1'b1; else ny = y - COORD_W'(1);
         RIGHT: if (x == '1) oob = 1'b1; else nx = x + COORD_W'(1);
         LEFT:  if (x == '0) oob = 1'b1; else nx = x - COORD_W'(1);
         DOWN:  if (y == '1) oob = 1'b1; else ny = y + COORD_W'(1);
         default: oob = 1'b0;
      endcase
   end

endmodule

// File: rtl/path_replayer.sv
// Drains the direction store, turning each code into an absolute position
// handed downstream over a valid/ready handshake; stops on an off-grid move.
module path_replayer
   import path_pkg::*;
#(
   parameter int unsigned COORD_W = COORD_W_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COORD_W-1:0] start_x,
   input  logic [COORD_W-1:0] start_y,
   input  logic               q_empty,
   input  logic [1:0]         q_data,
   output logic               q_dequeue,
   output logic               mv_valid,
   input  logic               mv_ready,
   output logic [1:0]         mv_dir,
   output logic [COORD_W-1:0] mv_x,
   output logic [COORD_W-1:0] mv_y,
   output logic [CNT_W-1:0]   move_cnt,
   output logic               busy,
   output logic               done,
   output logic               err
);

   state_t             state, nstate;
   logic [COORD_W-1:0] x, y, nx, ny;
   logic               oob;

   dir_step #(.COORD_W(COORD_W)) u_step (
      .x   (x),
      .y   (y),
      .dir (dir_t'(q_data)),
      .nx  (nx),
      .ny  (ny),
      .oob (oob)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate    = state;
      q_dequeue = 1'b0;
      mv_valid  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: if (start) nstate = POP;
         POP: begin
            busy = 1'b1;
            if (q_empty) begin
               nstate = DONE;
            end else begin
               q_dequeue = 1'b1;
               nstate    = CAP;
            end
         end
         CAP: begin
            busy   = 1'b1;
            nstate = oob ? DONE : SHOW;
         end
         SHOW: begin
            busy     = 1'b1;
            mv_valid = 1'b1;
            if (mv_ready) nstate = POP;
         end
         DONE: begin
            done = 1'b1;
            if (start) nstate = POP;
         end
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x        <= '0;
         y        <= '0;
         mv_dir   <= '0;
         mv_x     <= '0;
         mv_y     <= '0;
         move_cnt <= '0;
         err      <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: if (start) begin
               x        <= start_x;
               y        <= start_y;
               move_cnt <= '0;
               err      <= 1'b0;
            end
            CAP: begin
               if (oob) begin
                  err <= 1'b1;
               end else begin
                  x      <= nx;
                  y      <= ny;
                  mv_dir <= q_data;
                  mv_x   <= nx;
                  mv_y   <= ny;
               end
            end
            SHOW: if (mv_ready && move_cnt != '1) move_cnt <= move_cnt + CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_path_replayer.sv
// Directed-vector bench: stimulus pushes expected moves, a monitor pops and
// compares each accepted move; the store is modelled in the stimulus process.
module tb_path_replayer;
   import path_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] start_x, start_y;
   logic       q_empty;
   logic [1:0] q_data;
   logic       q_dequeue;
   logic       mv_valid;
   logic       mv_ready;
   logic [1:0] mv_dir;
   logic [3:0] mv_x, mv_y;
   logic [8:0] move_cnt;
   logic       busy, done, err;

   int vectors = 0;
   int miscompares = 0;
   int deq_cnt = 0;
   int valid_cycles = 0;
   int accepted = 0;
   logic prev_deq = 1'b0;

   logic [1:0] store[$];
   logic [9:0] exp_q[$];

   path_replayer #(.COORD_W(4), .CNT_W(9)) dut (
      .clk(clk), .rst(rst), .start(start), .start_x(start_x), .start_y(start_y),
      .q_empty(q_empty), .q_data(q_data), .q_dequeue(q_dequeue),
      .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_dir(mv_dir),
      .mv_x(mv_x), .mv_y(mv_y), .move_cnt(move_cnt),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: sample dequeue mid-cycle, then model the store pop just after the edge.
   task automatic tick();
      logic deq;
      @(negedge clk);
      deq = q_dequeue;
      if (deq) begin
         check("deq_when_empty", {31'd0, q_empty}, 32'd0);
         check("deq_back_to_back", {31'd0, prev_deq}, 32'd0);
         deq_cnt++;
      end
      prev_deq = deq;
      @(posedge clk);
      #1;
      if (deq && store.size() > 0) q_data = store.pop_front();
      q_empty = (store.size() == 0);
   endtask

   task automatic do_start(input logic [3:0] sx, input logic [3:0] sy);
      start_x = sx;
      start_y = sy;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 60) begin
         tick();
         n++;
      end
      check(name, {31'd0, done}, 32'd1);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!mv_valid && n < 20) begin
         tick();
         n++;
      end
      check(name, {31'd0, mv_valid}, 32'd1);
   endtask

   task automatic push_code(input logic [1:0] c);
      store.push_back(c);
      q_empty = 1'b0;
   endtask

   // Scoreboard monitor, plus a hold check for stalled moves.
   logic       stall = 1'b0;
   logic [9:0] held;
   always @(negedge clk) begin
      if (rst) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            check("stall_valid_held", {31'd0, mv_valid}, 32'd1);
            check("stall_data_held", {22'd0, mv_dir, mv_x, mv_y}, {22'd0, held});
         end
         if (mv_valid) valid_cycles++;
         if (mv_valid && mv_ready) begin
            accepted++;
            if (exp_q.size() == 0) check("unexpected_move", {22'd0, mv_dir, mv_x, mv_y}, 32'hFFFF_FFFF);
            else check("move", {22'd0, mv_dir, mv_x, mv_y}, {22'd0, exp_q.pop_front()});
         end
         stall = mv_valid && !mv_ready;
         held  = {mv_dir, mv_x, mv_y};
      end
   end

   typedef struct { logic [3:0] x; logic [3:0] y; logic [1:0] c; } bound_t;
   bound_t bounds[4];

   initial begin
      int d0, v0, a0;
      rst = 1'b1; start = 1'b0; start_x = '0; start_y = '0;
      q_empty = 1'b1; q_data = '0; mv_ready = 1'b1;
      #2;
      check("rst_outputs", {22'd0, q_dequeue, mv_valid, mv_dir, mv_x, mv_y},
            32'd0);
      check("rst_status", {20'd0, move_cnt, busy, done, err}, 32'd0);
      @(posedge clk); #1; @(posedge clk); #1;
      rst = 1'b0;
      tick();

      // Three-move replay from the origin.
      push_code(2'b01); push_code(2'b01); push_code(2'b11);
      exp_q.push_back({2'b01, 4'd1, 4'd0});
      exp_q.push_back({2'b01, 4'd2, 4'd0});
      exp_q.push_back({2'b11, 4'd2, 4'd1});
      d0 = deq_cnt;
      do_start(4'd0, 4'd0);
      check("busy_after_start", {31'd0, busy}, 32'd1);
      wait_done("t1_done");
      check("t1_cnt", {23'd0, move_cnt}, 32'd3);
      check("t1_err", {31'd0, err}, 32'd0);
      check("t1_deqs", deq_cnt - d0, 32'd3);
      check("t1_sb_empty", exp_q.size(), 32'd0);

      // Empty store: POP then DONE.
      d0 = deq_cnt; v0 = valid_cycles;
      do_start(4'd4, 4'd4);
      check("t2_done_1cyc", {31'd0, done}, 32'd0);
      tick();
      check("t2_done_2cyc", {31'd0, done}, 32'd1);
      check("t2_cnt", {23'd0, move_cnt}, 32'd0);
      check("t2_err", {31'd0, err}, 32'd0);
      check("t2_deqs", deq_cnt - d0, 32'd0);
      check("t2_valid", valid_cycles - v0, 32'd0);

      // Left from column 0.
      push_code(2'b10);
      d0 = deq_cnt; v0 = valid_cycles;
      do_start(4'd0, 4'd5);
      wait_done("t3_done");
      check("t3_err", {31'd0, err}, 32'd1);
      check("t3_cnt", {23'd0, move_cnt}, 32'd0);
      check("t3_deqs", deq_cnt - d0, 32'd1);
      check("t3_valid", valid_cycles - v0, 32'd0);

      // Backpressure on the first move.
      push_code(2'b11); push_code(2'b01);
      exp_q.push_back({2'b11, 4'd7, 4'd3});
      exp_q.push_back({2'b01, 4'd8, 4'd3});
      mv_ready = 1'b0;
      d0 = deq_cnt;
      do_start(4'd7, 4'd2);
      check("t4_err_cleared", {31'd0, err}, 32'd0);
      wait_valid("t4_valid_seen");
      for (int i = 0; i < 5; i++) tick();
      check("t4_deqs_stalled", deq_cnt - d0, 32'd1);
      a0 = accepted;
      mv_ready = 1'b1;
      tick();
      check("t4_first_ready", accepted - a0, 32'd1);
      wait_done("t4_done");
      check("t4_cnt", {23'd0, move_cnt}, 32'd2);
      check("t4_deqs", deq_cnt - d0, 32'd2);
      check("t4_sb_empty", exp_q.size(), 32'd0);

      // Reset while a move is showing, then replay from (3,3).
      push_code(2'b01); push_code(2'b01);
      exp_q.push_back({2'b01, 4'd1, 4'd0});
      mv_ready = 1'b0;
      do_start(4'd0, 4'd0);
      wait_valid("t5_valid_seen");
      rst = 1'b1;
      #1;
      check("t5_rst_outputs", {22'd0, q_dequeue, mv_valid, mv_dir, mv_x, mv_y}, 32'd0);
      check("t5_rst_status", {20'd0, move_cnt, busy, done, err}, 32'd0);
      exp_q.delete(); store.delete();
      q_empty = 1'b1; q_data = '0;
      tick();
      rst = 1'b0;
      mv_ready = 1'b1;
      push_code(2'b00); push_code(2'b01);
      exp_q.push_back({2'b00, 4'd3, 4'd2});
      exp_q.push_back({2'b01, 4'd4, 4'd2});
      do_start(4'd3, 4'd3);
      wait_done("t5_done");
      check("t5_cnt", {23'd0, move_cnt}, 32'd2);
      check("t5_sb_empty", exp_q.size(), 32'd0);

      // start while busy must be ignored.
      push_code(2'b11); push_code(2'b11); push_code(2'b01);
      exp_q.push_back({2'b11, 4'd0, 4'd1});
      exp_q.push_back({2'b11, 4'd0, 4'd2});
      exp_q.push_back({2'b01, 4'd1, 4'd2});
      do_start(4'd0, 4'd0);
      tick();
      start_x = 4'd9; start_y = 4'd9; start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      wait_done("t6_done");
      check("t6_cnt", {23'd0, move_cnt}, 32'd3);
      check("t6_sb_empty", exp_q.size(), 32'd0);

      // Remaining grid edges.
      bounds[0] = '{x: 4'd15, y: 4'd4,  c: 2'b01};
      bounds[1] = '{x: 4'd4,  y: 4'd15, c: 2'b11};
      bounds[2] = '{x: 4'd4,  y: 4'd0,  c: 2'b00};
      bounds[3] = '{x: 4'd0,  y: 4'd9,  c: 2'b10};
      foreach (bounds[i]) begin
         push_code(bounds[i].c);
         v0 = valid_cycles;
         do_start(bounds[i].x, bounds[i].y);
         wait_done("edge_done");
         check("edge_err", {31'd0, err}, 32'd1);
         check("edge_cnt", {23'd0, move_cnt}, 32'd0);
         check("edge_valid", valid_cycles - v0, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
